// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame input snapshot,
// per-digit enable, decimal points, leading-zero blanking and PWM brightness.
module seven_seg_scan #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 25000,
    parameter int unsigned BRIGHT_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned TICK_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    // Wide enough for REFRESH_DIV * (2^BRIGHT_W - 1) without truncation
    localparam int unsigned PROD_W = $clog2(REFRESH_DIV + 1) + BRIGHT_W;

    logic [TICK_W-1:0]       tick;
    logic [IDX_W-1:0]        idx;
    logic                    load_pending;
    logic [4*NUM_DIGITS-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   en_sh;
    logic                    lz_sh;
    logic [BRIGHT_W-1:0]     bright_sh;

    logic                    tick_wrap_c;
    logic                    frame_end_c;
    logic [TICK_W-1:0]       tick_next_c;
    logic [IDX_W-1:0]        idx_next_c;
    logic [PROD_W-1:0]       on_len_c;
    logic [3:0]              nib_c;
    logic                    en_c;
    logic                    dp_sel_c;
    logic                    upper_nz_c;
    logic                    lz_blank_c;
    logic                    visible_c;
    logic [6:0]              seg_next_c;
    logic                    dp_next_c;
    logic [NUM_DIGITS-1:0]   an_next_c;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Scan position bookkeeping
    always_comb begin
        tick_wrap_c = (tick == TICK_W'(REFRESH_DIV - 1));
        frame_end_c = tick_wrap_c && (idx == IDX_W'(NUM_DIGITS - 1));
        tick_next_c = tick_wrap_c ? '0 : tick + TICK_W'(1);
        idx_next_c  = idx;
        if (tick_wrap_c) begin
            idx_next_c = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end
    end

    // Current-digit selection, leading-zero detection and PWM window
    always_comb begin
        nib_c      = 4'h0;
        en_c       = 1'b0;
        dp_sel_c   = 1'b0;
        upper_nz_c = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == idx) begin
                nib_c    = digits_sh[4*j +: 4];
                en_c     = en_sh[j];
                dp_sel_c = dp_sh[j];
            end
            if ((IDX_W'(j) >= idx) && (digits_sh[4*j +: 4] != 4'h0)) begin
                upper_nz_c = 1'b1;
            end
        end
        on_len_c   = (PROD_W'(REFRESH_DIV) * PROD_W'(bright_sh)) >> BRIGHT_W;
        lz_blank_c = lz_sh && (idx != '0) && !upper_nz_c;
        visible_c  = en_c && !lz_blank_c && (PROD_W'(tick) < on_len_c);

        an_next_c  = '1;
        seg_next_c = 7'b1111111;
        dp_next_c  = 1'b1;
        if (visible_c) begin
            an_next_c  = ~(NUM_DIGITS'(1) << idx);
            seg_next_c = enc(nib_c);
            dp_next_c  = ~dp_sel_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick         <= '0;
            idx          <= '0;
            load_pending <= 1'b1;
            digits_sh    <= '0;
            dp_sh        <= '0;
            en_sh        <= '0;
            lz_sh        <= 1'b0;
            bright_sh    <= '0;
            an           <= '1;
            seg          <= 7'b1111111;
            dp           <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            tick         <= tick_next_c;
            idx          <= idx_next_c;
            load_pending <= 1'b0;
            // Snapshot inputs only at frame boundaries so a frame never tears
            if (load_pending || frame_end_c) begin
                digits_sh <= digits_in;
                dp_sh     <= dp_in;
                en_sh     <= digit_en;
                lz_sh     <= lz_suppress;
                bright_sh <= brightness;
            end
            an         <= an_next_c;
            seg        <= seg_next_c;
            dp         <= dp_next_c;
            frame_done <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: fixed vectors, corner sequences and
// randomized inputs against a frame/slot-level reference model.
module tb_seven_seg_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned BW = 2;
    localparam int unsigned FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_suppress = 1'b0;
    logic [1:0]  brightness = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(BW)) dut (
        .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .lz_suppress(lz_suppress), .brightness(brightness),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [6:0] enc_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: cycles since reset release plus the snapshot in effect
    int          m_p;
    logic [15:0] sh_dig;
    logic [3:0]  sh_dp, sh_en;
    logic        sh_lz;
    logic [1:0]  sh_br;

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dpi;
        logic [3:0]      en;
        logic            lz;
        logic [1:0]      br;
        logic [3:0][6:0] seg;
        logic [3:0]      dpo;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [12:0] model_out(input int p, input logic fd);
        int tick, idx, on_len;
        logic lzb, vis;
        tick   = p % RD;
        idx    = (p / RD) % ND;
        on_len = int'(RD * 32'(sh_br)) / (1 << BW);
        lzb    = sh_lz && idx != 0 && ((sh_dig >> (4 * idx)) == 16'h0);
        vis    = sh_en[idx] && !lzb && tick < on_len;
        if (vis) return {4'(~(1 << idx)), enc_tab[sh_dig[4*idx +: 4]], ~sh_dp[idx], fd};
        return {4'hF, 7'h7F, 1'b1, fd};
    endfunction

    task automatic step();
        logic [12:0] exp;
        logic        fd;
        fd  = (m_p % FRAME) == FRAME - 1;
        exp = model_out(m_p, fd);
        if (m_p == 0 || fd) begin
            sh_dig = digits_in; sh_dp = dp_in; sh_en = digit_en;
            sh_lz = lz_suppress; sh_br = brightness;
        end
        @(posedge clk);
        @(negedge clk);
        chk("cycle", 32'({an, seg, dp, frame_done}), 32'(exp));
        m_p++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp_fd", 32'({dp, frame_done}), 32'b10);
        @(negedge clk);
        m_p = 0;
        sh_dig = '0; sh_dp = '0; sh_en = '0; sh_lz = 1'b0; sh_br = '0;
        reset_n = 1'b1;
    endtask

    task automatic rand_inputs();
        logic [15:0] mask;
        case ($urandom_range(3))
            0: mask = 16'hFFFF;
            1: mask = 16'h00FF;
            2: mask = 16'h000F;
            default: mask = 16'h0000;
        endcase
        digits_in   = 16'($urandom) & mask;
        dp_in       = 4'($urandom);
        digit_en    = 4'($urandom) | 4'($urandom);
        lz_suppress = 1'($urandom);
        brightness  = 2'($urandom);
    endtask

    initial begin
        int fd_cnt, lit_cnt, s;
        logic [3:0] an_e;

        vecs[0] = '{16'h1A2F, 4'b0100, 4'hF, 1'b0, 2'd3,
                    {7'b1001111, 7'b0001000, 7'b0010010, 7'b0111000}, 4'b1011};
        vecs[1] = '{16'h0030, 4'b0000, 4'hF, 1'b1, 2'd3,
                    {7'h7F, 7'h7F, 7'b0000110, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0001, 4'hF, 1'b1, 2'd3,
                    {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1110};
        vecs[3] = '{16'h8421, 4'b1111, 4'b0101, 1'b0, 2'd3,
                    {7'h7F, 7'b1001100, 7'h7F, 7'b1001111}, 4'b1010};
        vecs[4] = '{16'h1234, 4'b1111, 4'hF, 1'b0, 2'd0,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
        vecs[5] = '{16'h0C05, 4'b0010, 4'hF, 1'b1, 2'd2,
                    {7'h7F, 7'b0110001, 7'b0000001, 7'b0100100}, 4'b1101};
        vecs[6] = '{16'hEDB9, 4'b0000, 4'hF, 1'b0, 2'd3,
                    {7'b0110000, 7'b1000010, 7'b1100000, 7'b0000100}, 4'b1111};
        vecs[7] = '{16'h6703, 4'b1000, 4'hF, 1'b1, 2'd3,
                    {7'b0100000, 7'b0001111, 7'b0000001, 7'b0000110}, 4'b0111};
        vecs[8] = '{16'h1A2F, 4'b1111, 4'hF, 1'b0, 2'd1,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};

        @(negedge clk);

        // Table vectors: second frame, tick 2 of each slot
        for (int i = 0; i < 9; i++) begin
            digits_in = vecs[i].digits; dp_in = vecs[i].dpi; digit_en = vecs[i].en;
            lz_suppress = vecs[i].lz; brightness = vecs[i].br;
            do_reset();
            for (int p = 0; p < 2 * FRAME; p++) begin
                step();
                if (p >= FRAME && p % RD == 2) begin
                    s = (p - FRAME) / RD;
                    an_e = (vecs[i].seg[s] == 7'h7F) ? 4'hF : 4'(~(1 << s));
                    chk("vec_an", 32'(an), 32'(an_e));
                    chk("vec_seg", 32'(seg), 32'(vecs[i].seg[s]));
                    chk("vec_dp", 32'(dp), (an_e == 4'hF) ? 32'd1 : 32'(vecs[i].dpo[s]));
                end
            end
        end

        // Snapshot: input change mid-frame shows only after the next frame end
        digits_in = 16'h1111; dp_in = '0; digit_en = 4'hF; lz_suppress = 1'b0; brightness = 2'd3;
        do_reset();
        for (int p = 0; p < 3 * FRAME; p++) begin
            if (p == 10) digits_in = 16'h2222;
            step();
            if (p == 26) chk("snap_old", 32'(seg), 32'b1001111);
            if (p == 34) chk("snap_new", 32'(seg), 32'b0010010);
        end

        // Brightness 0: dark for 3 frames, frame_done keeps pulsing
        brightness = 2'd0; digits_in = 16'h8888;
        do_reset();
        fd_cnt = 0; lit_cnt = 0;
        for (int p = 0; p < 3 * FRAME; p++) begin
            step();
            if (frame_done) fd_cnt++;
            if (an != 4'hF) lit_cnt++;
        end
        chk("dark_fd_count", 32'(fd_cnt), 32'd3);
        chk("dark_lit_count", 32'(lit_cnt), 32'd0);

        // Asynchronous reset in slot 2, then restart with fresh inputs
        digits_in = 16'h1234; brightness = 2'd3; digit_en = 4'hF;
        do_reset();
        for (int p = 0; p <= 18; p++) step();
        chk("pre_reset_an", 32'(an), 32'b1011);
        #2 reset_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg_dp_fd", 32'({seg, dp, frame_done}), 32'({7'h7F, 1'b1, 1'b0}));
        @(negedge clk);
        digits_in = 16'h5679;
        m_p = 0;
        sh_dig = '0; sh_dp = '0; sh_en = '0; sh_lz = 1'b0; sh_br = '0;
        reset_n = 1'b1;
        for (int p = 0; p < 2 * FRAME; p++) begin
            step();
            if (p == 2) begin
                chk("restart_an", 32'(an), 32'b1110);
                chk("restart_seg", 32'(seg), 32'b0000100);
            end
        end

        // Randomized inputs against the model
        for (int r = 0; r < 6; r++) begin
            rand_inputs();
            do_reset();
            for (int p = 0; p < 240; p++) begin
                if ($urandom_range(7) == 0) rand_inputs();
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
